custom_mem_arbiter: RTL and testbench

CUSTOM_MEM_ARBITER -- requirements
Module: custom_mem_arbiter

---
 rtl/custom_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_custom_mem_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_mem_arbiter.sv
// Two-requester round-robin front end for a single memory slave.
// Issued requests are tagged in an in-order ID FIFO so responses route back to their source.
module custom_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         s0_mem_req,
  output logic                         s0_mem_gnt,
  input  logic [ADDR_WIDTH-1:0]        s0_mem_addr,
  input  logic                         s0_mem_we,
  input  logic [DATA_WIDTH/8-1:0]      s0_mem_be,
  input  logic [DATA_WIDTH-1:0]        s0_mem_wdata,
  output logic                         s0_mem_valid,
  output logic [DATA_WIDTH-1:0]        s0_mem_rdata,
  output logic                         s0_mem_error,
  input  logic                         s1_mem_req,
  output logic                         s1_mem_gnt,
  input  logic [ADDR_WIDTH-1:0]        s1_mem_addr,
  input  logic                         s1_mem_we,
  input  logic [DATA_WIDTH/8-1:0]      s1_mem_be,
  input  logic [DATA_WIDTH-1:0]        s1_mem_wdata,
  output logic                         s1_mem_valid,
  output logic [DATA_WIDTH-1:0]        s1_mem_rdata,
  output logic                         s1_mem_error,
  output logic                         m_mem_req,
  output logic [ADDR_WIDTH-1:0]        m_mem_addr,
  output logic                         m_mem_we,
  output logic [DATA_WIDTH/8-1:0]      m_mem_be,
  output logic [DATA_WIDTH-1:0]        m_mem_wdata,
  input  logic                         m_mem_gnt,
  input  logic                         m_mem_valid,
  input  logic [DATA_WIDTH-1:0]        m_mem_rdata,
  input  logic                         m_mem_error,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                         protocol_err_o
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic [CW-1:0]              r_count;
  logic [PW-1:0]              r_wptr;
  logic [PW-1:0]              r_rptr;
  logic [MAX_OUTSTANDING-1:0] r_id_fifo;
  logic                       r_prio;
  logic                       r_perr;

  logic w_full;
  logic w_sel;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_full = (r_count == CW'(MAX_OUTSTANDING));
  assign w_head = r_id_fifo[r_rptr];
  assign w_pop  = m_mem_valid & (r_count != {CW{1'b0}});

  // Requester selection: lone requester wins, contention resolved by the priority pointer
  always_comb begin
    w_sel = 1'b0;
    if (s0_mem_req && !s1_mem_req) begin
      w_sel = 1'b0;
    end else if (!s0_mem_req && s1_mem_req) begin
      w_sel = 1'b1;
    end else if (s0_mem_req && s1_mem_req) begin
      w_sel = r_prio;
    end else begin
      w_sel = 1'b0;
    end
  end

  // Request path to memory; reset gating keeps handshakes quiet while rst_ni is low
  always_comb begin
    m_mem_req   = rst_ni & (s0_mem_req | s1_mem_req) & ~w_full;
    m_mem_addr  = {ADDR_WIDTH{1'b0}};
    m_mem_we    = 1'b0;
    m_mem_be    = {(DATA_WIDTH/8){1'b0}};
    m_mem_wdata = {DATA_WIDTH{1'b0}};
    if (m_mem_req) begin
      m_mem_addr  = w_sel ? s1_mem_addr  : s0_mem_addr;
      m_mem_we    = w_sel ? s1_mem_we    : s0_mem_we;
      m_mem_be    = w_sel ? s1_mem_be    : s0_mem_be;
      m_mem_wdata = w_sel ? s1_mem_wdata : s0_mem_wdata;
    end else begin
      m_mem_addr  = {ADDR_WIDTH{1'b0}};
    end
    w_push     = m_mem_req & m_mem_gnt;
    s0_mem_gnt = w_push & ~w_sel;
    s1_mem_gnt = w_push & w_sel;
  end

  // Response routing to the requester at the FIFO head
  always_comb begin
    s0_mem_valid = 1'b0;
    s0_mem_rdata = {DATA_WIDTH{1'b0}};
    s0_mem_error = 1'b0;
    s1_mem_valid = 1'b0;
    s1_mem_rdata = {DATA_WIDTH{1'b0}};
    s1_mem_error = 1'b0;
    if (w_pop && w_head) begin
      s1_mem_valid = 1'b1;
      s1_mem_rdata = m_mem_rdata;
      s1_mem_error = m_mem_error;
    end else if (w_pop) begin
      s0_mem_valid = 1'b1;
      s0_mem_rdata = m_mem_rdata;
      s0_mem_error = m_mem_error;
    end else begin
      s0_mem_valid = 1'b0;
    end
  end

  // ID FIFO storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count   <= {CW{1'b0}};
      r_wptr    <= {PW{1'b0}};
      r_rptr    <= {PW{1'b0}};
      r_id_fifo <= {MAX_OUTSTANDING{1'b0}};
    end else begin
      if (w_push) begin
        r_id_fifo[r_wptr] <= w_sel;
        r_wptr            <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Round-robin pointer moves to the loser after each grant; sticky protocol error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_push) begin
        r_prio <= ~w_sel;
      end
      if (m_mem_valid && (r_count == {CW{1'b0}})) begin
        r_perr <= 1'b1;
      end
    end
  end

  assign outstanding_o  = r_count;
  assign protocol_err_o = r_perr;

endmodule

// File: tb/tb_custom_mem_arbiter.sv
// Scenario bench for custom_mem_arbiter: expected responses are queued at issue time
// and compared against whichever requester the DUT delivers to.
module tb_custom_mem_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_req = 1'b0, s1_req = 1'b0;
  logic        s0_gnt, s1_gnt;
  logic [31:0] s0_addr = 32'd0, s1_addr = 32'd0;
  logic        s0_we = 1'b0, s1_we = 1'b0;
  logic [3:0]  s0_be = 4'd0, s1_be = 4'd0;
  logic [31:0] s0_wdata = 32'd0, s1_wdata = 32'd0;
  logic        s0_valid, s1_valid;
  logic [31:0] s0_rdata, s1_rdata;
  logic        s0_err, s1_err;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_gnt = 1'b0, m_valid = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;
  logic [2:0]  outstanding;
  logic        perr;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mem_q[$];
  exp_t mon_e;

  custom_mem_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s0_mem_req(s0_req), .s0_mem_gnt(s0_gnt), .s0_mem_addr(s0_addr), .s0_mem_we(s0_we),
    .s0_mem_be(s0_be), .s0_mem_wdata(s0_wdata), .s0_mem_valid(s0_valid),
    .s0_mem_rdata(s0_rdata), .s0_mem_error(s0_err),
    .s1_mem_req(s1_req), .s1_mem_gnt(s1_gnt), .s1_mem_addr(s1_addr), .s1_mem_we(s1_we),
    .s1_mem_be(s1_be), .s1_mem_wdata(s1_wdata), .s1_mem_valid(s1_valid),
    .s1_mem_rdata(s1_rdata), .s1_mem_error(s1_err),
    .m_mem_req(m_req), .m_mem_addr(m_addr), .m_mem_we(m_we), .m_mem_be(m_be),
    .m_mem_wdata(m_wdata), .m_mem_gnt(m_gnt), .m_mem_valid(m_valid),
    .m_mem_rdata(m_rdata), .m_mem_error(m_err),
    .outstanding_o(outstanding), .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s0_req = 1'b0; s1_req = 1'b0; s0_we = 1'b0; s1_we = 1'b0;
    m_gnt = 1'b0; m_valid = 1'b0; m_rdata = 32'd0; m_err = 1'b0;
  endtask

  // Record an issue: the response the requester must see, and what the memory will return
  task automatic expect_issue(input logic id, input logic [31:0] d, input logic e);
    exp_q.push_back('{id: id, data: d, err: e});
    mem_q.push_back('{id: id, data: d, err: e});
  endtask

  // In-order memory model: return the oldest issued transaction
  task automatic drive_resp();
    exp_t e;
    e = '0;
    if (mem_q.size() != 0) e = mem_q.pop_front();
    m_valid = 1'b1; m_rdata = e.data; m_err = e.err;
  endtask

  task automatic drain(input int n);
    s0_req = 1'b0; s1_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive_resp();
      @(negedge clk);
      next_cycle();
    end
    m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s0_req = 1'b1; s1_req = 1'b1; m_gnt = 1'b1; m_valid = 1'b1;
    #2;
    checks++;
    if ({s0_gnt, s1_gnt, m_req, s0_valid, s1_valid, perr} !== 6'b000000 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b mreq=%b valid=%b%b perr=%b out=%0d, required all 0",
               s0_gnt, s1_gnt, m_req, s0_valid, s1_valid, perr, outstanding);
    end
    idle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      logic id;
      id = i[0];
      s0_req = 1'b1; s1_req = 1'b1; m_gnt = 1'b1;
      s0_addr = 32'h1000 + i; s1_addr = 32'h2000 + i;
      expect_issue(id, 32'hC0DE_0000 + i, 1'b0);
      @(negedge clk);
      checks++;
      if (s0_gnt !== !id || s1_gnt !== id) begin
        errors++;
        $display("FAIL rr_grant[%0d]: gnt s0=%b s1=%b, required s%0d", i, s0_gnt, s1_gnt, id);
      end
      checks++;
      if (m_addr !== (id ? s1_addr : s0_addr)) begin
        errors++;
        $display("FAIL rr_addr[%0d]: m_addr=%h, required %h", i, m_addr, id ? s1_addr : s0_addr);
      end
      next_cycle();
    end
    m_gnt = 1'b0;
    drain(4);
    checks++;
    if (outstanding !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: outstanding=%0d pending=%0d, required 0 0", outstanding, exp_q.size());
    end
  endtask

  task automatic test_single();
    int  peak;
    logic s1_seen;
    peak = 0; s1_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      s0_req = (c < 3); s0_we = 1'b0; s0_addr = 32'h100 + 4 * c; m_gnt = 1'b1;
      m_valid = 1'b0;
      if (c < 3) expect_issue(1'b0, 32'hA000_0000 + c, 1'b0);
      if (c >= 2 && c < 5) drive_resp();
      @(negedge clk);
      if (int'(outstanding) > peak) peak = int'(outstanding);
      s1_seen = s1_seen | s1_valid | s1_gnt;
      checks++;
      if (s0_gnt !== (c < 3) || m_req !== (c < 3)) begin
        errors++;
        $display("FAIL single_gnt[%0d]: s0_gnt=%b m_req=%b, required %b", c, s0_gnt, m_req, c < 3);
      end
      if (c >= 3) begin
        checks++;
        if (m_addr !== 32'd0) begin
          errors++;
          $display("FAIL single_idle_addr[%0d]: m_addr=%h, required 0", c, m_addr);
        end
      end
      next_cycle();
    end
    idle();
    checks++;
    if (peak != 2) begin
      errors++;
      $display("FAIL single_peak: outstanding peak=%0d, required 2", peak);
    end
    checks++;
    if (s1_seen !== 1'b0 || outstanding !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_end: s1_activity=%b outstanding=%0d pending=%0d, required 0 0 0",
               s1_seen, outstanding, exp_q.size());
    end
  endtask

  task automatic test_full();
    for (int c = 0; c < 7; c++) begin
      logic g;
      g = (c < 4) || (c == 6);
      s0_req = 1'b1; s0_addr = 32'h300 + c; m_gnt = 1'b1; m_valid = 1'b0;
      if (g) expect_issue(1'b0, 32'hB000_0000 + c, 1'b0);
      if (c == 5) drive_resp();
      @(negedge clk);
      checks++;
      if (s0_gnt !== g || m_req !== g) begin
        errors++;
        $display("FAIL full_gnt[%0d]: s0_gnt=%b m_req=%b, required %b", c, s0_gnt, m_req, g);
      end
      if (c == 4) begin
        checks++;
        if (outstanding !== 3'd4 || m_addr !== 32'd0) begin
          errors++;
          $display("FAIL full_state: outstanding=%0d m_addr=%h, required 4 0", outstanding, m_addr);
        end
      end
      next_cycle();
    end
    m_gnt = 1'b0;
    drain(4);
    checks++;
    if (outstanding !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_drain: outstanding=%0d pending=%0d, required 0 0", outstanding, exp_q.size());
    end
  endtask

  // Last grant went to s0, so the pointer favours s1 and must hold while m_mem_gnt is low
  task automatic test_backpressure();
    s0_req = 1'b1; s1_req = 1'b1; m_gnt = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (m_req !== 1'b1 || s0_gnt !== 1'b0 || s1_gnt !== 1'b0 || m_addr !== s1_addr) begin
        errors++;
        $display("FAIL bp_hold[%0d]: m_req=%b gnt=%b%b m_addr=%h, required 1 00 %h",
                 c, m_req, s0_gnt, s1_gnt, m_addr, s1_addr);
      end
      next_cycle();
    end
    for (int c = 0; c < 2; c++) begin
      m_gnt = 1'b1;
      expect_issue(c == 0, 32'hD000_0000 + c, c == 0);
      @(negedge clk);
      checks++;
      if (s1_gnt !== (c == 0) || s0_gnt !== (c == 1)) begin
        errors++;
        $display("FAIL bp_resume[%0d]: gnt s0=%b s1=%b, required s%0d", c, s0_gnt, s1_gnt, c == 0);
      end
      next_cycle();
    end
    m_gnt = 1'b0;
    drain(2);
  endtask

  task automatic test_order();
    logic        ids[3];
    logic [3:0]  bes[3];
    logic [31:0] dat[3];
    ids = '{1'b1, 1'b0, 1'b1};
    bes = '{4'hF, 4'h3, 4'hC};
    dat = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    for (int c = 0; c < 3; c++) begin
      s0_req = !ids[c]; s1_req = ids[c]; m_gnt = 1'b1;
      s0_we = 1'b0; s0_be = bes[c]; s0_addr = 32'h400 + c; s0_wdata = 32'h5555_0000 + c;
      s1_we = 1'b1; s1_be = bes[c]; s1_addr = 32'h500 + c; s1_wdata = 32'h6666_0000 + c;
      expect_issue(ids[c], dat[c], ids[c]);
      @(negedge clk);
      checks++;
      if (s1_gnt !== ids[c] || s0_gnt !== !ids[c] || m_we !== ids[c] || m_be !== bes[c] ||
          m_wdata !== (ids[c] ? s1_wdata : s0_wdata)) begin
        errors++;
        $display("FAIL order_issue[%0d]: gnt=%b%b we=%b be=%h wdata=%h, required s%0d we=%b be=%h",
                 c, s0_gnt, s1_gnt, m_we, m_be, m_wdata, ids[c], ids[c], bes[c]);
      end
      next_cycle();
    end
    m_gnt = 1'b0;
    drain(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL order_pending: %0d responses undelivered, required 0", exp_q.size());
    end
  endtask

  task automatic test_protocol_err();
    idle();
    checks++;
    if (perr !== 1'b0 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL perr_pre: perr=%b outstanding=%0d, required 0 0", perr, outstanding);
    end
    m_valid = 1'b1; m_rdata = 32'hFFFF_FFFF; m_err = 1'b1;
    @(negedge clk);
    checks++;
    if (s0_valid !== 1'b0 || s1_valid !== 1'b0) begin
      errors++;
      $display("FAIL perr_drop: valid s0=%b s1=%b, required 0 0", s0_valid, s1_valid);
    end
    next_cycle();
    idle();
    checks++;
    if (perr !== 1'b1) begin
      errors++;
      $display("FAIL perr_set: perr=%b, required 1", perr);
    end
    repeat (3) next_cycle();
    checks++;
    if (perr !== 1'b1 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL perr_sticky: perr=%b outstanding=%0d, required 1 0", perr, outstanding);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      s0_req = (c == 0); s1_req = (c == 1); m_gnt = 1'b1;
      expect_issue(c == 1, 32'hE000_0000 + c, 1'b0);
      @(negedge clk);
      next_cycle();
    end
    checks++;
    if (outstanding !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_pre: outstanding=%0d, required 2", outstanding);
    end
    s0_req = 1'b1; s1_req = 1'b1; m_valid = 1'b1; m_rdata = 32'h1234_5678;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s0_gnt, s1_gnt, m_req, s0_valid, s1_valid, perr} !== 6'b000000 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: gnt=%b%b mreq=%b valid=%b%b perr=%b out=%0d, required all 0",
               s0_gnt, s1_gnt, m_req, s0_valid, s1_valid, perr, outstanding);
    end
    exp_q.delete();
    mem_q.delete();
    idle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    m_valid = 1'b1; m_rdata = 32'hE000_0000;
    @(negedge clk);
    next_cycle();
    m_valid = 1'b0;
    checks++;
    if (perr !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_late_resp: perr=%b, required 1", perr);
    end
    s0_req = 1'b1; s1_req = 1'b1; m_gnt = 1'b1;
    expect_issue(1'b0, 32'hF000_0001, 1'b0);
    @(negedge clk);
    checks++;
    if (s0_gnt !== 1'b1 || s1_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_prio: gnt s0=%b s1=%b, required s0", s0_gnt, s1_gnt);
    end
    next_cycle();
    m_gnt = 1'b0;
    drain(1);
    checks++;
    if (outstanding !== 3'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_end: outstanding=%0d pending=%0d, required 0 0", outstanding, exp_q.size());
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (s0_valid || s1_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: valid s0=%b s1=%b, required none", s0_valid, s1_valid);
          end else begin
            mon_e = exp_q.pop_front();
            if ((s0_valid && s1_valid) || s1_valid !== mon_e.id ||
                (s1_valid ? s1_rdata : s0_rdata) !== mon_e.data ||
                (s1_valid ? s1_err : s0_err) !== mon_e.err) begin
              errors++;
              $display("FAIL resp_route: valid=%b%b data=%h err=%b, required s%0d data=%h err=%b",
                       s0_valid, s1_valid, s1_valid ? s1_rdata : s0_rdata,
                       s1_valid ? s1_err : s0_err, mon_e.id, mon_e.data, mon_e.err);
            end
          end
          checks++;
          if (s1_valid ? (s0_rdata !== 32'd0 || s0_err !== 1'b0)
                       : (s1_rdata !== 32'd0 || s1_err !== 1'b0)) begin
            errors++;
            $display("FAIL resp_other_side: s0 rdata=%h err=%b s1 rdata=%h err=%b, required idle side 0",
                     s0_rdata, s0_err, s1_rdata, s1_err);
          end
        end
      end
    join_none
    test_reset();
    test_round_robin();
    test_single();
    test_full();
    test_backpressure();
    test_order();
    test_protocol_err();
    test_reset_mid();
    repeat (2) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
